pipe_skid_reg: RTL

Elastic two-entry pipeline register with valid/ready handshakes on both sides, placed between CPU pipeline stages where the downstream stage can stall. It is the consumer-facing counterpart of the plain stage flip-flop: it accepts a word from the upstream stage, presents it downstream, and absorbs one extra word when downstream back-pressure arrives. A synchronous flush empties it for branch and exception redirects. Throughput is one word per cycle. No combinational path runs from `out_ready` to `in_ready`.

---
 rtl/pipe_skid_reg.sv | 88 ++++++++
 1 files changed

// File: rtl/pipe_skid_reg.sv
// Two-entry elastic pipeline register (main + skid), valid/ready on both sides, synchronous flush.
// Latency 1 cycle, 1 word/cycle; in_ready is registered-state decode only, so no out_ready->in_ready path.
module pipe_skid_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             accept;
  logic             pop;

  assign accept   = in_valid & in_ready;
  assign pop      = out_valid & out_ready;
  assign out_data = main_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY:   if (accept) state_d = ONE;
        ONE: begin
          if (accept && !pop)      state_d = FULL;
          else if (!accept && pop) state_d = EMPTY;
        end
        FULL:    if (pop) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid = (state_q != EMPTY);
    in_ready  = rst & (state_q != FULL);
    case (state_q)
      ONE:     count = 2'd1;
      FULL:    count = 2'd2;
      default: count = 2'd0;
    endcase
  end

  // A word accepted while one is held and not leaving goes to skid; otherwise it lands in main.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      case (state_q)
        EMPTY: if (accept) main_q <= in_data;
        ONE: begin
          if (accept && pop)       main_q <= in_data;
          else if (accept && !pop) skid_q <= in_data;
        end
        FULL:  if (pop) main_q <= skid_q;
        default: ;
      endcase
    end
  end

endmodule
